qnigma_alu_seq: RTL
===================

// Module: qnigma_alu_seq
// PURPOSE
//  Parametrised sequential multi-precision ALU: add, sub and full-width multiply
//  on W-bit operands, processed in K-bit limbs using N K-by-K multipliers per cycle.
//  Successor to the fixed 32-bit ALU core. Adds configurable width, a busy
//  handshake, command priority and a registered equality flag.
//  Used as the arithmetic engine behind the crypto and bignum datapath.
// PARAMETERS
//  W  32  operand width in bits; must be a multiple of K
//  K  8   limb width in bits (adder slice and multiplier width)
//  N  4   multipliers used per cycle; must divide M = W/K
// PORTS
//  clk  in   1    clock
//  rst  in   1    synchronous reset, active-high
//  opa  in   W    operand A; sampled on an accepted cal
//  opb  in   W    operand B; sampled on an accepted cal
//  add  in   1    select add
//  sub  in   1    select subtract
//  mul  in   1    select multiply
//  cal  in   1    1-cycle start strobe
//  res  out  2W   result; held until the next completion
//  ovf  out  1    add: carry out; sub: borrow (A<B); mul: 0
//  eql  out  1    opa==opb as sampled at accept; updated with don
//  don  out  1    1-cycle completion pulse
//  bsy  out  1    high from the cycle after accept through the don cycle
// BEHAVIOUR
//  Reset: res=0, ovf=0, eql=0, don=0, bsy=0, FSM=IDLE. Reset mid-operation
//   aborts the operation: no don pulse, and the previous res is lost.
//  Accept: cal=1 in IDLE with at least one op bit set. Priority mul > sub > add.
//   cal with no op bit set, or cal while bsy=1, is ignored and has no side effects.
//  Accept latches opa, opb, the op, eql_next=(opa==opb) and an internal
//   carry/borrow (0 for add, 1 for sub). Sub computes A + ~B + 1.
//  FSM: IDLE -> ADD (add/sub) or MUL -> DONE -> IDLE. DONE lasts 1 cycle,
//   drives don=1 and updates res/ovf/eql in the same cycle.
//  ADD: one limb per cycle, LSB first; M cycles. Per-limb carry is registered.
//  MUL: schoolbook. Row j (B limb j) takes M/N cycles; each cycle covers N limbs
//   of A. Partial products are added into a 2W accumulator at offset
//   (i+j)*K, carry propagated in full. Total M*M/N cycles.
//  Latency (cal accepted at cycle 0): don at cycle M+1 for add/sub and
//   at cycle M*M/N+1 for mul. Defaults: add/sub 5, mul 5.
//  A new cal is accepted in the cycle after don (back-to-back ops are allowed).
//  Width rules:
//   add/sub: res[W-1:0] = result mod 2^W, res[2W-1:W] = 0.
//   sub ovf = ~(final carry).
//   mul: res = exact 2W-bit unsigned product, ovf = 0.
//  Inputs opa/opb may change freely while bsy=1; only the latched copies are used.
// TESTING
//  1 add 0xFFFFFFFF+0x00000001 -> res=0, ovf=1, eql=0; don exactly at cycle 5,
//    bsy high on cycles 1..5.
//  2 sub 5-7 -> res=0x0000_0000_FFFF_FFFE, ovf=1;
//    sub 7-7 -> res=0, ovf=0, eql=1.
//  3 mul 0xFFFFFFFF*0xFFFFFFFF -> res=0xFFFFFFFE_00000001, ovf=0;
//    mul 0x12345678*0 -> res=0.
//  4 add+mul set together with A=3, B=4 -> mul executes, res=12.
//    cal with no op bits -> no bsy, no don.
//  5 cal asserted on cycle 2 of a busy add -> ignored: one don, and the result
//    of the first op only. cal on the cycle after don -> accepted.
//  6 rst on cycle 3 of a mul -> no don, res=0, bsy=0; the next add completes
//    normally. Rerun tests 1-3 with W=64, K=16, N=2
//    (add latency 5, mul latency 9).

Source files
------------

// File: rtl/qnigma_alu_seq.sv
// Sequential multi-precision ALU: add/sub one K-bit limb per cycle, and a
// schoolbook multiply using N K-by-K multipliers per cycle into a 2W accumulator.
module qnigma_alu_seq #(
    parameter int W = 32,
    parameter int K = 8,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   opa,
    input  logic [W-1:0]   opb,
    input  logic           add,
    input  logic           sub,
    input  logic           mul,
    input  logic           cal,
    output logic [2*W-1:0] res,
    output logic           ovf,
    output logic           eql,
    output logic           don,
    output logic           bsy
);

    localparam int M  = W / K;
    localparam int R  = M / N;
    localparam int CW = (M > 1) ? $clog2(M) : 1;

    localparam logic [CW-1:0] LAST_LIMB  = CW'(M - 1);
    localparam logic [CW-1:0] LAST_CHUNK = CW'(R - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_MUL,
        S_DONE
    } state_t;

    state_t         state;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [2*W-1:0] acc;
    logic           carry;
    logic           is_sub;
    logic           eql_next;
    logic [CW-1:0]  limb_idx;
    logic [CW-1:0]  row_idx;

    logic [K:0]     limb_sum;
    logic [W-1:0]   add_word;
    logic [2*W-1:0] partial;
    logic [2*W-1:0] mul_sum;
    logic [2*K-1:0] prod;
    logic [K-1:0]   a_limb;
    logic [K-1:0]   b_limb;
    int             chunk_base;
    int             row_base;

    // Add/sub datapath: b_reg already holds ~B for subtract, carry starts at 1.
    always_comb begin
        limb_sum = {1'b0, a_reg[int'(limb_idx)*K +: K]}
                 + {1'b0, b_reg[int'(limb_idx)*K +: K]}
                 + {{K{1'b0}}, carry};
        add_word = acc[W-1:0];
        add_word[int'(limb_idx)*K +: K] = limb_sum[K-1:0];
    end

    // One multiply step: N limbs of A (chunk limb_idx) times B limb row_idx.
    always_comb begin
        chunk_base = int'(limb_idx) * N;
        row_base   = int'(row_idx);
        partial    = '0;
        prod       = '0;
        a_limb     = '0;
        b_limb     = b_reg[row_base*K +: K];
        for (int n = 0; n < N; n++) begin
            a_limb  = a_reg[(chunk_base + n)*K +: K];
            prod    = {{K{1'b0}}, a_limb} * {{K{1'b0}}, b_limb};
            partial = partial
                    + ({{(2*W-2*K){1'b0}}, prod} << ((chunk_base + n + row_base)*K));
        end
        mul_sum = acc + partial;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            is_sub   <= 1'b0;
            eql_next <= 1'b0;
            limb_idx <= '0;
            row_idx  <= '0;
            res      <= '0;
            ovf      <= 1'b0;
            eql      <= 1'b0;
            don      <= 1'b0;
            bsy      <= 1'b0;
        end else begin
            don <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cal && (add || sub || mul)) begin
                        a_reg    <= opa;
                        eql_next <= (opa == opb);
                        acc      <= '0;
                        limb_idx <= '0;
                        row_idx  <= '0;
                        bsy      <= 1'b1;
                        if (mul) begin
                            b_reg  <= opb;
                            carry  <= 1'b0;
                            is_sub <= 1'b0;
                            state  <= S_MUL;
                        end else if (sub) begin
                            b_reg  <= ~opb;
                            carry  <= 1'b1;
                            is_sub <= 1'b1;
                            state  <= S_ADD;
                        end else begin
                            b_reg  <= opb;
                            carry  <= 1'b0;
                            is_sub <= 1'b0;
                            state  <= S_ADD;
                        end
                    end
                end
                S_ADD: begin
                    carry    <= limb_sum[K];
                    acc      <= {{W{1'b0}}, add_word};
                    limb_idx <= limb_idx + 1'b1;
                    if (limb_idx == LAST_LIMB) begin
                        res   <= {{W{1'b0}}, add_word};
                        ovf   <= limb_sum[K] ^ is_sub;
                        eql   <= eql_next;
                        don   <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_MUL: begin
                    acc <= mul_sum;
                    if (limb_idx == LAST_CHUNK) begin
                        limb_idx <= '0;
                        row_idx  <= row_idx + 1'b1;
                        if (row_idx == LAST_LIMB) begin
                            res   <= mul_sum;
                            ovf   <= 1'b0;
                            eql   <= eql_next;
                            don   <= 1'b1;
                            state <= S_DONE;
                        end
                    end else begin
                        limb_idx <= limb_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    bsy   <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
